// File: rtl/idelay_multi_pkg.sv
// idelay_multi_pkg: shared constants for the multi-lane tap delay line.
//   MODE_*    : values of the IDELAY_TYPE parameter
//   SETTLE_W  : width of the per-lane settle counter (SETTLE range 1..15)
package idelay_multi_pkg;
  localparam int MODE_FIXED    = 0;
  localparam int MODE_VARIABLE = 1;
  localparam int MODE_VAR_LOAD = 2;

  localparam int SETTLE_W = 4;
endpackage

// File: rtl/idelay_multi_if.sv
// idelay_multi_if: lane data and tap-control bundle for idelay_multi.
//   master : drives din, ce, inc, ld, ldpipeen, cntvaluein (pad sampler / align FSM)
//   slave  : the delay block; drives dout, cntvalueout, settled
// Lane k of a packed tap bus lives at [k*TAP_W +: TAP_W].
interface idelay_multi_if #(
  parameter int NCH   = 4,
  parameter int TAP_W = 5
);
  logic [NCH-1:0]       din;
  logic [NCH-1:0]       ce;
  logic [NCH-1:0]       inc;
  logic [NCH-1:0]       ld;
  logic [NCH-1:0]       ldpipeen;
  logic [NCH*TAP_W-1:0] cntvaluein;
  logic [NCH-1:0]       dout;
  logic [NCH*TAP_W-1:0] cntvalueout;
  logic [NCH-1:0]       settled;

  modport master (
    output din, ce, inc, ld, ldpipeen, cntvaluein,
    input  dout, cntvalueout, settled
  );

  modport slave (
    input  din, ce, inc, ld, ldpipeen, cntvaluein,
    output dout, cntvalueout, settled
  );
endinterface

// File: rtl/idelay_multi_lane.sv
// idelay_multi_lane: one lane of the tap delay line.
//   clk, rst    : clock, asynchronous active-high reset
//   din         : lane input (optionally inverted by INV)
//   ce, inc     : tap step enable and direction (1 up, 0 down, modulo 2**TAP_W)
//   ld          : tap load strobe, priority over ce
//   ldpipeen    : pipe register capture strobe (only with IDELAY_MULTI_LDPIPE_EN)
//   cntvaluein  : load value
//   dout        : delayed output, registered; dout(n) = din(n-tap-1)
//   cntvalueout : current tap register
//   settled     : high once the tap has been untouched for SETTLE cycles
// Optional feature: macro IDELAY_MULTI_LDPIPE_EN adds a pipe register so a
// VAR_LOAD ld takes the previously captured value instead of cntvaluein.
module idelay_multi_lane
  import idelay_multi_pkg::*;
#(
  parameter int TAP_W        = 5,
  parameter int IDELAY_TYPE  = MODE_FIXED,
  parameter int IDELAY_VALUE = 0,
  parameter int SETTLE       = 3,
  parameter bit INV          = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             ce,
  input  logic             inc,
  input  logic             ld,
  input  logic             ldpipeen,
  input  logic [TAP_W-1:0] cntvaluein,
  output logic             dout,
  output logic [TAP_W-1:0] cntvalueout,
  output logic             settled
);
  localparam int                   DEPTH       = 1 << TAP_W;
  localparam logic [TAP_W-1:0]     TAP_INIT    = TAP_W'(IDELAY_VALUE);
  localparam logic [SETTLE_W-1:0]  SETTLE_INIT = SETTLE_W'(SETTLE);
  localparam bit                   TAP_CTRL    = (IDELAY_TYPE != MODE_FIXED);
  localparam bit                   LOAD_EXT    = (IDELAY_TYPE == MODE_VAR_LOAD);

  logic [DEPTH-1:0]    sh_q, sh_d;
  logic                dout_q, dout_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [TAP_W-1:0]    load_val;
  logic                evt;

`ifdef IDELAY_MULTI_LDPIPE_EN
  // ld reads pipe_q before this edge's capture, so ld+ldpipeen together
  // loads the old contents while the new value is staged.
  logic [TAP_W-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = pipe_q;
    if (TAP_CTRL && ldpipeen) pipe_d = cntvaluein;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign load_val = pipe_q;
`else
  logic unused_ldpipeen;
  assign unused_ldpipeen = ldpipeen;
  assign load_val        = cntvaluein;
`endif

  always_comb begin
    evt   = TAP_CTRL && (ld || ce);
    tap_d = tap_q;
    cnt_d = cnt_q;

    if (!TAP_CTRL)  tap_d = TAP_INIT;
    else if (ld)    tap_d = LOAD_EXT ? load_val : TAP_INIT;
    else if (ce)    tap_d = inc ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);

    // Any accepted event restarts the settle window, even a no-op load.
    if (evt)                cnt_d = SETTLE_INIT;
    else if (cnt_q != '0)   cnt_d = cnt_q - SETTLE_W'(1);

    sh_d   = {sh_q[DEPTH-2:0], din ^ INV};
    dout_d = sh_q[tap_q];
  end

  // stage boundary: delay line, output tap, tap and settle registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      dout_q <= 1'b0;
      tap_q  <= TAP_INIT;
      cnt_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      dout_q <= dout_d;
      tap_q  <= tap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout        = dout_q;
  assign cntvalueout = tap_q;
  assign settled     = (cnt_q == '0);
endmodule

// File: rtl/idelay_multi.sv
// idelay_multi: NCH independent programmable tap delay lanes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : idelay_multi_if.slave (din, ce, inc, ld, ldpipeen, cntvaluein in;
//              dout, cntvalueout, settled out)
// Parameters: NCH lanes, TAP_W tap width (depth 2**TAP_W), IDELAY_TYPE
// (0 FIXED, 1 VARIABLE, 2 VAR_LOAD), IDELAY_VALUE reset tap, SETTLE cycles,
// INV_MASK per-lane input inversion.
// Optional feature: macro IDELAY_MULTI_LDPIPE_EN enables per-lane load pipe registers.
module idelay_multi
  import idelay_multi_pkg::*;
#(
  parameter int             NCH          = 4,
  parameter int             TAP_W        = 5,
  parameter int             IDELAY_TYPE  = MODE_FIXED,
  parameter int             IDELAY_VALUE = 0,
  parameter int             SETTLE       = 3,
  parameter logic [NCH-1:0] INV_MASK     = '0
) (
  input  logic          clk,
  input  logic          rst,
  idelay_multi_if.slave bus
);
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    idelay_multi_lane #(
      .TAP_W       (TAP_W),
      .IDELAY_TYPE (IDELAY_TYPE),
      .IDELAY_VALUE(IDELAY_VALUE),
      .SETTLE      (SETTLE),
      .INV         (INV_MASK[k])
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .din        (bus.din[k]),
      .ce         (bus.ce[k]),
      .inc        (bus.inc[k]),
      .ld         (bus.ld[k]),
      .ldpipeen   (bus.ldpipeen[k]),
      .cntvaluein (bus.cntvaluein[k*TAP_W +: TAP_W]),
      .dout       (bus.dout[k]),
      .cntvalueout(bus.cntvalueout[k*TAP_W +: TAP_W]),
      .settled    (bus.settled[k])
    );
  end
endmodule

// File: tb/tb_idelay_multi.sv
// tb_idelay_multi: directed bench for idelay_multi. Three instances share
// clk/rst: FIXED (tap 7), VARIABLE (tap 0) and VAR_LOAD (tap 3, lane 3 inverted).
module tb_idelay_multi;
  localparam int NCH   = 4;
  localparam int TAP_W = 5;
  localparam int W     = NCH * TAP_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  idelay_multi_if #(.NCH(NCH), .TAP_W(TAP_W)) if_fix ();
  idelay_multi_if #(.NCH(NCH), .TAP_W(TAP_W)) if_var ();
  idelay_multi_if #(.NCH(NCH), .TAP_W(TAP_W)) if_vl  ();

  idelay_multi #(.NCH(NCH), .TAP_W(TAP_W), .IDELAY_TYPE(0), .IDELAY_VALUE(7),
                 .SETTLE(3), .INV_MASK(4'b0000))
    u_fix (.clk(clk), .rst(rst), .bus(if_fix.slave));

  idelay_multi #(.NCH(NCH), .TAP_W(TAP_W), .IDELAY_TYPE(1), .IDELAY_VALUE(0),
                 .SETTLE(3), .INV_MASK(4'b0000))
    u_var (.clk(clk), .rst(rst), .bus(if_var.slave));

  idelay_multi #(.NCH(NCH), .TAP_W(TAP_W), .IDELAY_TYPE(2), .IDELAY_VALUE(3),
                 .SETTLE(3), .INV_MASK(4'b1000))
    u_vl (.clk(clk), .rst(rst), .bus(if_vl.slave));

  function automatic logic [W-1:0] pack(input int t0, input int t1, input int t2, input int t3);
    return {TAP_W'(t3), TAP_W'(t2), TAP_W'(t1), TAP_W'(t0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_fix.din = '0; if_fix.ce = '0; if_fix.inc = '0; if_fix.ld = '0;
    if_fix.ldpipeen = '0; if_fix.cntvaluein = '0;
    if_var.din = '0; if_var.ce = '0; if_var.inc = '0; if_var.ld = '0;
    if_var.ldpipeen = '0; if_var.cntvaluein = '0;
    if_vl.din = '0; if_vl.ce = '0; if_vl.inc = '0; if_vl.ld = '0;
    if_vl.ldpipeen = '0; if_vl.cntvaluein = '0;

    // reset state
    repeat (2) tick();
    check("rst_fix_tap", if_fix.cntvalueout, pack(7, 7, 7, 7));
    check("rst_vl_tap",  if_vl.cntvalueout,  pack(3, 3, 3, 3));
    check("rst_var_tap", if_var.cntvalueout, pack(0, 0, 0, 0));
    check("rst_var_settled", if_var.settled, 4'hf);
    check("rst_vl_dout", if_vl.dout, 4'h0);
    rst = 1'b0;

    // FIXED: pulse sampled at edge p appears at p+8; ld/ce ignored
    if_fix.din = 4'b0001; if_fix.ld = '1; if_fix.ce = '1; if_fix.inc = '1;
    tick();
    if_fix.din = 4'b0000; if_fix.inc = '0;
    repeat (7) tick();
    check("fix_dout_p7", if_fix.dout, 4'b0000);
    tick();
    check("fix_dout_p8", if_fix.dout, 4'b0001);
    tick();
    check("fix_dout_p9", if_fix.dout, 4'b0000);
    check("fix_tap_hold", if_fix.cntvalueout, pack(7, 7, 7, 7));
    check("fix_settled", if_fix.settled, 4'hf);
    if_fix.ld = '0; if_fix.ce = '0;

    // VARIABLE: wrap down, wrap up, wrap down, then settle window
    if_var.ce = 4'b0001; if_var.inc = 4'b0000;
    tick();
    check("var_dec_wrap", if_var.cntvalueout, pack(31, 0, 0, 0));
    check("var_settle_low", if_var.settled, 4'b1110);
    if_var.inc = 4'b0001;
    tick();
    check("var_inc_wrap", if_var.cntvalueout, pack(0, 0, 0, 0));
    if_var.inc = 4'b0000;
    tick();
    check("var_dec_wrap2", if_var.cntvalueout, pack(31, 0, 0, 0));
    if_var.ce = '0;
    repeat (2) tick();
    check("var_settle_n2", if_var.settled, 4'b1110);
    tick();
    check("var_settle_n3", if_var.settled, 4'b1111);

    // steps on each lane at successive edges
    if_var.inc = 4'b1111;
    if_var.ce = 4'b0001; tick(); check("ind_e0", if_var.settled, 4'b1110);
    if_var.ce = 4'b0010; tick(); check("ind_e1", if_var.settled, 4'b1100);
    if_var.ce = 4'b0100; tick(); check("ind_e2", if_var.settled, 4'b1000);
    if_var.ce = 4'b1000; tick(); check("ind_e3", if_var.settled, 4'b0001);
    if_var.ce = 4'b0000; tick(); check("ind_e4", if_var.settled, 4'b0011);
    check("ind_taps", if_var.cntvalueout, pack(0, 1, 1, 1));

    // VAR_LOAD: inverted lane, loads, ld-over-ce priority, 13-cycle delay
    check("vl_inv_lane3", if_vl.dout, 4'b1000);
    if_vl.cntvaluein = pack(0, 20, 12, 0); if_vl.ldpipeen = 4'b0110;
    tick();
    if_vl.ldpipeen = '0; if_vl.ld = 4'b0110; if_vl.ce = 4'b0010; if_vl.inc = 4'b0010;
    if_vl.din = 4'b0100;
    tick();
    check("vl_load", if_vl.cntvalueout, pack(3, 20, 12, 3));
    check("vl_settled", if_vl.settled, 4'b1001);
    if_vl.ld = '0; if_vl.ce = '0; if_vl.din = '0;
    repeat (12) tick();
    check("vl_dout_12", if_vl.dout, 4'b1000);
    tick();
    check("vl_dout_13", if_vl.dout, 4'b1100);
    tick();
    check("vl_dout_14", if_vl.dout, 4'b1000);

`ifdef IDELAY_MULTI_LDPIPE_EN
    if_vl.cntvaluein = pack(5, 0, 0, 0); if_vl.ldpipeen = 4'b0001;
    tick();
    if_vl.cntvaluein = pack(9, 0, 0, 0); if_vl.ld = 4'b0001;
    tick();
    check("pipe_old", if_vl.cntvalueout, pack(5, 20, 12, 3));
    if_vl.ld = '0; if_vl.ldpipeen = '0; if_vl.cntvaluein = '0;
    tick();
    if_vl.ld = 4'b0001;
    tick();
    check("pipe_new", if_vl.cntvalueout, pack(9, 20, 12, 3));
    if_vl.ld = '0;
`else
    if_vl.cntvaluein = pack(9, 0, 0, 0); if_vl.ld = 4'b0001; if_vl.ldpipeen = 4'b0001;
    tick();
    check("direct_ld", if_vl.cntvalueout, pack(9, 20, 12, 3));
    if_vl.ld = '0; if_vl.ldpipeen = '0;
    if_vl.cntvaluein = pack(6, 0, 0, 0); if_vl.ld = 4'b0001;
    tick();
    check("direct_ld2", if_vl.cntvalueout, pack(6, 20, 12, 3));
    if_vl.ld = '0; if_vl.cntvaluein = '0;
`endif

    // async reset in the middle of a sweep
    if_var.ce = '1; if_var.inc = '1;
    repeat (3) tick();
    check("sweep_taps", if_var.cntvalueout, pack(3, 4, 4, 4));
    #2 rst = 1'b1;
    #1;
    check("arst_var_tap", if_var.cntvalueout, pack(0, 0, 0, 0));
    check("arst_var_settled", if_var.settled, 4'hf);
    check("arst_vl_tap", if_vl.cntvalueout, pack(3, 3, 3, 3));
    check("arst_vl_dout", if_vl.dout, 4'b0000);
    if_var.ce = '0;
    tick();
    rst = 1'b0;
    tick();
    check("cold_var_tap", if_var.cntvalueout, pack(0, 0, 0, 0));
    check("cold_var_settled", if_var.settled, 4'hf);
    if_var.ce = 4'b0001; if_var.inc = 4'b0001;
    tick();
    check("cold_step", if_var.cntvalueout, pack(1, 0, 0, 0));
    check("cold_settle", if_var.settled, 4'b1110);
    if_var.ce = '0;
    repeat (8) tick();
    check("cold_vl_inv", if_vl.dout, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
